// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, NZCV-style flags and an iterative shift-add multiplier.
// One operation in flight; back-to-back acceptance when the consumer is ready.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic             accept, is_mul, is_sub, ovf, mul_last;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_cf, alu_vf, alu_err;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_step, mul_res;
  logic [SHW-1:0]   cnt;

  assign is_mul   = MUL_EN && (op == 4'd11);
  assign is_sub   = (op == 4'd1);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHW-1:0];
  assign b_eff    = is_sub ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign mul_last = (cnt == SHW'(WIDTH-2));

  // The last BUSY cycle folds in the top multiplier bit as well: b[WIDTH-1]
  // only ever contributes a[0] to the MSB, which keeps MUL latency at WIDTH.
  assign acc_step = acc + (b_sh[0] ? a_sh : '0);
  assign mul_res  = acc_step + {b_sh[1] & a_sh[WIDTH-2], {(WIDTH-1){1'b0}}};

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    alu_err = 1'b0;
    case (op)
      4'd0:  begin alu_res = sum[WIDTH-1:0]; alu_cf = sum[WIDTH];  alu_vf = ovf; end
      4'd1:  begin alu_res = sum[WIDTH-1:0]; alu_cf = ~sum[WIDTH]; alu_vf = ovf; end
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd5:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'd6:  alu_res = a ^ b;
      4'd7:  alu_res = ~(a | b);
      4'd8:  alu_res = a << shamt;
      4'd9:  alu_res = a >> shamt;
      4'd10: alu_res = $signed(a) >>> shamt;
      4'd11: alu_err = !MUL_EN;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (mul_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? (is_mul ? BUSY : DONE) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zf     <= 1'b1;
      nf     <= 1'b0;
      cf     <= 1'b0;
      vf     <= 1'b0;
      err    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && !is_mul) begin
      result <= alu_res;
      zf     <= (alu_res == '0);
      nf     <= alu_res[WIDTH-1];
      cf     <= alu_cf;
      vf     <= alu_vf;
      err    <= alu_err;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= acc_step;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + SHW'(1);
      if (mul_last) begin
        result <= mul_res;
        zf     <= (mul_res == '0);
        nf     <= mul_res[WIDTH-1];
        cf     <= 1'b0;
        vf     <= 1'b0;
        err    <= 1'b0;
      end
    end
  end
endmodule
